// File: rtl/mem_stage_dm.sv
// MIPS memory-access stage: data memory with byte/half/word loads and stores,
// W-stage store-data forwarding and the MEM/WB pipeline register.
// Optional: define DM_DISPLAY_EN to print each committed store.
module mem_stage_dm #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] V2_3,
  input  logic [4:0]  A2_3,
  input  logic [4:0]  A3_3,
  input  logic [31:0] AO_3,
  input  logic [31:0] pc4_3,
  input  logic [31:0] pc_3,
  input  logic [3:0]  mem_op,
  input  logic [31:0] wd_w,
  input  logic [4:0]  a3_w,
  input  logic        rw_w,
  output logic [31:0] AO_34,
  output logic [31:0] DR_34,
  output logic [4:0]  A3_34,
  output logic [31:0] pc4_34,
  output logic [31:0] pc_34,
  output logic        exc_34
);

  localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  logic [31:0]           mem_q [WORDS];
  logic [31:0]           ao_q, dr_q, pc4_q, pc_q;
  logic [4:0]            a3_q;
  logic                  exc_q;

  mem_op_e               op;
  logic [ADDR_WIDTH-3:0] widx;
  logic [1:0]            boff;
  logic [31:0]           rword;
  logic [31:0]           sd;
  logic [31:0]           wword;
  logic [31:0]           dr_d;
  logic [15:0]           half_v;
  logic [7:0]            byte_v;
  logic                  mis;
  logic                  st_en;
  logic                  unused_hi;

  assign op        = mem_op_e'(mem_op);
  assign widx      = AO_3[ADDR_WIDTH-1:2];
  assign boff      = AO_3[1:0];
  assign rword     = mem_q[widx];
  assign unused_hi = ^AO_3[31:ADDR_WIDTH];

  // Forward the W-stage result when it targets the store's source register.
  assign sd = (rw_w && (a3_w == A2_3) && (A2_3 != 5'd0)) ? wd_w : V2_3;

  always_comb begin
    half_v = boff[1] ? rword[31:16] : rword[15:0];
    byte_v = rword[{boff, 3'b000} +: 8];
    mis    = 1'b0;
    st_en  = 1'b0;
    dr_d   = '0;
    wword  = rword;
    case (op)
      OP_LW: begin
        mis  = (boff != 2'b00);
        dr_d = rword;
      end
      OP_LH: begin
        mis  = boff[0];
        dr_d = {{16{half_v[15]}}, half_v};
      end
      OP_LHU: begin
        mis  = boff[0];
        dr_d = {16'h0000, half_v};
      end
      OP_LB:  dr_d = {{24{byte_v[7]}}, byte_v};
      OP_LBU: dr_d = {24'h000000, byte_v};
      OP_SW: begin
        mis   = (boff != 2'b00);
        st_en = 1'b1;
        wword = sd;
      end
      OP_SH: begin
        mis   = boff[0];
        st_en = 1'b1;
        if (boff[1]) wword[31:16] = sd[15:0];
        else         wword[15:0]  = sd[15:0];
      end
      OP_SB: begin
        st_en = 1'b1;
        wword[{boff, 3'b000} +: 8] = sd[7:0];
      end
      default: ;
    endcase
    if (mis) begin
      dr_d  = '0;
      st_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) mem_q[i] <= '0;
      ao_q  <= '0;
      dr_q  <= '0;
      a3_q  <= '0;
      pc4_q <= '0;
      pc_q  <= '0;
      exc_q <= 1'b0;
    end else begin
      if (st_en) begin
        mem_q[widx] <= wword;
`ifdef DM_DISPLAY_EN
        $display("@%h: *%h <= %h", pc_3, {AO_3[31:2], 2'b00}, wword);
`else
`endif
      end
      ao_q  <= AO_3;
      dr_q  <= dr_d;
      a3_q  <= A3_3;
      pc4_q <= pc4_3;
      pc_q  <= pc_3;
      exc_q <= mis;
    end
  end

  assign AO_34  = ao_q;
  assign DR_34  = dr_q;
  assign A3_34  = a3_q;
  assign pc4_34 = pc4_q;
  assign pc_34  = pc_q;
  assign exc_34 = exc_q;

endmodule

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
- Memory-access stage of the five-stage MIPS pipeline.
- Consumes the EX/MEM pipeline register outputs: rt value, rt index, destination index, ALU result as address, pc+4 and pc.
- Performs data-memory loads and stores: word, halfword and byte, signed and unsigned.
- Forwards W-stage results into the store data, and registers everything into the MEM/WB boundary for the write-back stage.

Parameters:
- ADDR_WIDTH, 12, byte-address width of data memory (4 KiB); word count = 2^(ADDR_WIDTH-2).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- V2_3  in  32  rt register value from EX/MEM
- A2_3  in  5  rt index from EX/MEM
- A3_3  in  5  destination register index from EX/MEM
- AO_3  in  32  ALU result; byte address for loads and stores
- pc4_3  in  32  pc+4 from EX/MEM
- pc_3  in  32  pc from EX/MEM
- mem_op  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as none
- wd_w  in  32  W-stage write-back data
- a3_w  in  5  W-stage destination index
- rw_w  in  1  W-stage register-write enable
- AO_34  out  32  registered ALU result
- DR_34  out  32  registered, extended load data
- A3_34  out  5  registered destination index
- pc4_34  out  32  registered pc+4
- pc_34  out  32  registered pc
- exc_34  out  1  registered misaligned-access flag

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on reset. All state updates only on the rising edge of clk.
- Reset:
  - Every output clears to 0.
  - All memory words clear to 0.
  - Any store presented in the same cycle is discarded.
  - Reset mid-operation simply overrides that cycle.
- Address decode:
  - word index = AO_3[ADDR_WIDTH-1:2]; upper address bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH.
  - Little-endian: byte k of a word = bits [8k+7:8k]; halfword h = bits [16h+15:16h].
- Store data forwarding (combinational):
  - sd = wd_w when rw_w=1, a3_w==A2_3 and A2_3!=0.
  - Otherwise sd = V2_3.
- Misalignment (combinational): mis = 1 when
  - lw/sw with AO_3[1:0]!=0, or
  - lh/lhu/sh with AO_3[0]!=0.
  - Byte operations are never misaligned.
- Stores, committed on the rising edge when reset=0 and mis=0:
  - sw writes the whole word.
  - sh writes the addressed halfword from sd[15:0].
  - sb writes the addressed byte from sd[7:0].
  - Other lanes are preserved.
  - A misaligned store writes nothing.
- Loads:
  - Combinational read of the current word; lane selected by AO_3[1:0].
  - lh and lb sign-extend; lhu and lbu zero-extend.
  - Result is registered into DR_34 (1-cycle latency).
  - DR_34 = 0 for non-load ops and for misaligned loads.
- Store followed by load:
  - A load in the cycle after a store to the same word observes the new data.
  - No read-during-write case exists within one cycle, since there is one instruction per stage.
- Pipeline register, each cycle when reset=0:
  - AO_34<=AO_3, A3_34<=A3_3, pc4_34<=pc4_3, pc_34<=pc_3, exc_34<=mis.
  - No stall or flush inputs; the stage always advances.

Optional Feature:
- Macro: DM_DISPLAY_EN.
- When defined:
  - Each committed store issues one simulation $display of the form "@%h: *%h <= %h".
  - Fields: pc_3, the word-aligned byte address, and the full resulting 32-bit word.
  - No print on misaligned, reset or non-store cycles.
- When undefined:
  - No display statements are compiled.
  - Functional behaviour is identical.

Test Plan:
1. Word round trip: reset 1 cycle; sw V2_3=0x12345678 AO_3=0x0; next cycle lw AO_3=0x0 -> DR_34=0x12345678 one edge later, exc_34=0.
2. Byte store and loads: sb V2_3=0x000000AB at AO_3=0x5 (word 0x4 = 0):
   - lb 0x5 -> DR_34=0xFFFFFFAB
   - lbu 0x5 -> 0x000000AB
   - lw 0x4 -> 0x0000AB00
3. Halfword store and loads: sh V2_3=0x00008001 at AO_3=0x2 (word 0 = 0):
   - lh -> 0xFFFF8001
   - lhu -> 0x00008001
   - lw 0x0 -> 0x80010000
   - lb 0x3 -> 0xFFFFFF80
4. Forwarding:
   - sw V2_3=0x1, A2_3=5, a3_w=5, rw_w=1, wd_w=0xDEADBEEF at 0x8 -> lw 0x8 returns 0xDEADBEEF.
   - Repeat with A2_3=a3_w=0 -> returns 0x1.
   - Repeat with rw_w=0 -> returns 0x1.
5. Misalignment and wrap:
   - sw at 0x6 -> memory unchanged, exc_34=1.
   - lh at 0x1 -> DR_34=0, exc_34=1.
   - sw 0x55 at AO_3=0x1000 then lw 0x0 -> 0x55.
6. Reset mid-operation: sw 0xFFFFFFFF at 0x10 with reset=1 -> no write; all outputs 0; subsequent lw 0x10 -> 0. Previously written words also read 0.
